mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 Ports (name / direction / width / meaning) SHALL be:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- EX_VALID, in, 1: EX-stage instruction valid.
- EX_ALU_RES, in, 32: ALU result; byte address for memory operations.
- EX_RS2_DATA, in, 32: store data.
- EX_MEM_RD / EX_MEM_WR, in, 1 each: load / store.
- EX_SIZE, in, 2: 00 = byte, 01 = half, 10 or 11 = word.
- EX_UNSIGNED, in, 1: zero-extend loads.
- EX_RF_D_SEL, in, 2; EX_NEXT_PC, in, 32; EX_RD_SEL, in, 2: pass-through.
- DM_REQ, out, 1; DM_WE, out, 1; DM_ADDR, out, 32; DM_BE, out, 4; DM_WDATA, out, 32: data-memory request.
- DM_ACK, in, 1; DM_RDATA, in, 32: data-memory response.
- MEM_VALID, out, 1; MEM_ALU_RES, out, 32; MEM_DM_Q, out, 32; MEM_RF_D_SEL, out, 2; MEM_NEXT_PC, out, 32; MEM_RD_SEL, out, 2: feed the MEM/WB register.
- STALL, out, 1: upstream SHALL hold EX_* while high.
- MISALIGN, out, 1: one-cycle misaligned-access flag.

Function
REQ-003 State machine states SHALL be IDLE and ACCESS.
REQ-004 Definitions:
- memop = EX_VALID & (EX_MEM_RD | EX_MEM_WR).
- mis = memop & ((half & addr[0]) | (word & addr[1:0] != 0)).
- accept = IDLE & memop & !mis.
REQ-005 Non-memory instruction in IDLE: at the next edge, MEM_* SHALL capture EX_* with MEM_VALID = EX_VALID and MEM_DM_Q = 0; latency is 1 cycle; STALL stays 0.
REQ-006 On accept:
- Next edge: state goes to ACCESS; DM_REQ=1; DM_WE=EX_MEM_WR; DM_ADDR={addr[31:2],2'b00}; MEM_VALID=0.
- Pass-through fields, MEM_ALU_RES and EX_UNSIGNED/EX_SIZE/addr[1:0] are held internally.
REQ-007 DM_BE (little-endian) SHALL be:
- byte: 0001<<addr[1:0].
- half: 0011<<(2*addr[1]).
- word: 1111.
REQ-008 DM_WDATA SHALL be:
- byte: the data byte replicated 4 times.
- half: the data half replicated 2 times.
- word: EX_RS2_DATA.
REQ-009 All DM_* outputs SHALL remain constant from DM_REQ rise until the edge at which DM_ACK=1 is sampled.
REQ-010 In ACCESS with DM_ACK=1 at an edge:
- State returns to IDLE; DM_REQ=0.
- MEM_VALID=1 for one cycle; MEM_* take the held values.
- For loads, MEM_DM_Q = the selected lane of DM_RDATA, sign- or zero-extended to 32 bits. For stores, MEM_DM_Q = 0.
REQ-011 In ACCESS without DM_ACK: state holds; MEM_VALID=0; EX_* SHALL be ignored.
REQ-012 STALL SHALL be combinational: accept | (ACCESS & !DM_ACK). Total stall = 1 + the number of ACCESS cycles without ACK.
REQ-013 An instruction with mis=1 in IDLE SHALL NOT issue DM_REQ; at the next edge MISALIGN=1 for one cycle and MEM_VALID=0.
REQ-014 DM_ACK sampled in IDLE SHALL be ignored.
REQ-015 EX_MEM_RD and EX_MEM_WR both high SHALL be treated as a store.

Reset
REQ-016 While rst=1, the block SHALL immediately force state=IDLE and all outputs to 0, including DM_REQ, STALL, MISALIGN and MEM_VALID.
REQ-017 Reset asserted during ACCESS SHALL abort the access; no MEM_VALID pulse SHALL result for that access after release.
REQ-018 After reset release, the first edge SHALL behave as IDLE.

Verification
REQ-019 ALU op, EX_ALU_RES=0x00001234, EX_VALID=1 -> next edge MEM_ALU_RES=0x00001234, MEM_VALID=1, STALL=0 throughout.
REQ-020 Signed byte load at 0x103; DM_RDATA=0x80FF0000; ACK after 2 wait cycles -> DM_ADDR=0x100, DM_BE=1000, STALL high for 3 cycles, MEM_DM_Q=0xFFFFFF80, MEM_VALID pulses 1 cycle.
REQ-021 Half store at 0x22, EX_RS2_DATA=0x0000ABCD, immediate ACK -> DM_WE=1, DM_BE=1100, DM_WDATA=0xABCDABCD, STALL high exactly 1 cycle.
REQ-022 Word load at 0x101 -> DM_REQ never rises; MISALIGN=1 for 1 cycle; MEM_VALID=0.
REQ-023 rst pulsed in ACCESS cycle 2 with DM_ACK=0 -> DM_REQ=0 and STALL=0 immediately; after release, no MEM_VALID pulse for that access.
REQ-024 Unsigned half load at 0x002, DM_RDATA=0x9876_0000 -> MEM_DM_Q=0x00009876.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundle of the EX-side inputs, data-memory request/response and MEM/WB-side
// outputs of the memory stage. slave = the memory stage, master = its surroundings.
interface mem_stage_if;
  logic        EX_VALID;
  logic [31:0] EX_ALU_RES;
  logic [31:0] EX_RS2_DATA;
  logic        EX_MEM_RD;
  logic        EX_MEM_WR;
  logic [1:0]  EX_SIZE;
  logic        EX_UNSIGNED;
  logic [1:0]  EX_RF_D_SEL;
  logic [31:0] EX_NEXT_PC;
  logic [1:0]  EX_RD_SEL;

  logic        DM_REQ;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [3:0]  DM_BE;
  logic [31:0] DM_WDATA;
  logic        DM_ACK;
  logic [31:0] DM_RDATA;

  logic        MEM_VALID;
  logic [31:0] MEM_ALU_RES;
  logic [31:0] MEM_DM_Q;
  logic [1:0]  MEM_RF_D_SEL;
  logic [31:0] MEM_NEXT_PC;
  logic [1:0]  MEM_RD_SEL;

  logic        STALL;
  logic        MISALIGN;

  modport slave (
    input  EX_VALID, EX_ALU_RES, EX_RS2_DATA, EX_MEM_RD, EX_MEM_WR, EX_SIZE,
           EX_UNSIGNED, EX_RF_D_SEL, EX_NEXT_PC, EX_RD_SEL, DM_ACK, DM_RDATA,
    output DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA, MEM_VALID, MEM_ALU_RES,
           MEM_DM_Q, MEM_RF_D_SEL, MEM_NEXT_PC, MEM_RD_SEL, STALL, MISALIGN
  );

  modport master (
    output EX_VALID, EX_ALU_RES, EX_RS2_DATA, EX_MEM_RD, EX_MEM_WR, EX_SIZE,
           EX_UNSIGNED, EX_RF_D_SEL, EX_NEXT_PC, EX_RD_SEL, DM_ACK, DM_RDATA,
    input  DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA, MEM_VALID, MEM_ALU_RES,
           MEM_DM_Q, MEM_RF_D_SEL, MEM_NEXT_PC, MEM_RD_SEL, STALL, MISALIGN
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one data-memory access per load/store, stalls
// the upstream until the memory acknowledges, and aligns/extends load data.
//
// state  | meaning
// IDLE   | no access outstanding; non-memory instructions pass in one cycle
// ACCESS | request on DM_*, waiting for DM_ACK; EX_* ignored
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;

  logic [31:0] addr;
  logic        memop, is_half, is_word, mis, accept;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;

  // Held copy of the accepted instruction for the cycle DM_ACK arrives.
  logic [31:0] alu_q, next_pc_q;
  logic [1:0]  rf_d_sel_q, rd_sel_q, size_q, off_q;
  logic        uns_q, load_q;

  logic [31:0] byte_sh, half_sh, load_data;

  logic        dm_req, dm_we, mem_valid, misalign;
  logic [31:0] dm_addr, dm_wdata, mem_alu_res, mem_dm_q, mem_next_pc;
  logic [3:0]  dm_be;
  logic [1:0]  mem_rf_d_sel, mem_rd_sel;

  assign addr    = bus.EX_ALU_RES;
  assign memop   = bus.EX_VALID & (bus.EX_MEM_RD | bus.EX_MEM_WR);
  assign is_half = (bus.EX_SIZE == 2'b01);
  assign is_word = bus.EX_SIZE[1];
  assign mis     = memop & ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
  assign accept  = (state == IDLE) & memop & ~mis;

  // Gated by rst so the upstream sees no stall while the block is held in reset.
  assign bus.STALL = ~rst & (accept | ((state == ACCESS) & ~bus.DM_ACK));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  if (bus.DM_ACK) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte enables and lane-replicated store data for the incoming instruction.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = bus.EX_RS2_DATA;
    case (bus.EX_SIZE)
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{bus.EX_RS2_DATA[7:0]}};
      end
      2'b01: begin
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{bus.EX_RS2_DATA[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select and sign/zero extension of returned load data.
  always_comb begin
    byte_sh   = bus.DM_RDATA >> {off_q, 3'b000};
    half_sh   = bus.DM_RDATA >> {off_q[1], 4'b0000};
    load_data = bus.DM_RDATA;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'd0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   load_data = uns_q ? {16'd0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
      default: ;
    endcase
    if (!load_q) load_data = 32'd0;
  end

  // Request, hold and MEM/WB output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req       <= 1'b0;
      dm_we        <= 1'b0;
      dm_addr      <= 32'd0;
      dm_be        <= 4'd0;
      dm_wdata     <= 32'd0;
      mem_valid    <= 1'b0;
      misalign     <= 1'b0;
      mem_alu_res  <= 32'd0;
      mem_dm_q     <= 32'd0;
      mem_rf_d_sel <= 2'd0;
      mem_next_pc  <= 32'd0;
      mem_rd_sel   <= 2'd0;
      alu_q        <= 32'd0;
      next_pc_q    <= 32'd0;
      rf_d_sel_q   <= 2'd0;
      rd_sel_q     <= 2'd0;
      size_q       <= 2'd0;
      off_q        <= 2'd0;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      misalign  <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          dm_req     <= 1'b1;
          dm_we      <= bus.EX_MEM_WR;
          dm_addr    <= {addr[31:2], 2'b00};
          dm_be      <= be_nxt;
          dm_wdata   <= wdata_nxt;
          alu_q      <= addr;
          next_pc_q  <= bus.EX_NEXT_PC;
          rf_d_sel_q <= bus.EX_RF_D_SEL;
          rd_sel_q   <= bus.EX_RD_SEL;
          size_q     <= bus.EX_SIZE;
          off_q      <= addr[1:0];
          uns_q      <= bus.EX_UNSIGNED;
          load_q     <= ~bus.EX_MEM_WR;
        end else if (mis) begin
          misalign <= 1'b1;
        end else begin
          mem_valid    <= bus.EX_VALID;
          mem_alu_res  <= addr;
          mem_dm_q     <= 32'd0;
          mem_rf_d_sel <= bus.EX_RF_D_SEL;
          mem_next_pc  <= bus.EX_NEXT_PC;
          mem_rd_sel   <= bus.EX_RD_SEL;
        end
      end else if (bus.DM_ACK) begin
        dm_req       <= 1'b0;
        mem_valid    <= 1'b1;
        mem_alu_res  <= alu_q;
        mem_dm_q     <= load_data;
        mem_rf_d_sel <= rf_d_sel_q;
        mem_next_pc  <= next_pc_q;
        mem_rd_sel   <= rd_sel_q;
      end
    end
  end

  assign bus.DM_REQ       = dm_req;
  assign bus.DM_WE        = dm_we;
  assign bus.DM_ADDR      = dm_addr;
  assign bus.DM_BE        = dm_be;
  assign bus.DM_WDATA     = dm_wdata;
  assign bus.MEM_VALID    = mem_valid;
  assign bus.MISALIGN     = misalign;
  assign bus.MEM_ALU_RES  = mem_alu_res;
  assign bus.MEM_DM_Q     = mem_dm_q;
  assign bus.MEM_RF_D_SEL = mem_rf_d_sel;
  assign bus.MEM_NEXT_PC  = mem_next_pc;
  assign bus.MEM_RD_SEL   = mem_rd_sel;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic,
// with expectations computed from byte counts and offsets arithmetically.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_stage_if bus();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ex_idle();
    bus.EX_VALID    = 1'b0;
    bus.EX_MEM_RD   = 1'b0;
    bus.EX_MEM_WR   = 1'b0;
    bus.EX_ALU_RES  = 32'd0;
    bus.EX_RS2_DATA = 32'd0;
    bus.EX_SIZE     = 2'd0;
    bus.EX_UNSIGNED = 1'b0;
    bus.EX_RF_D_SEL = 2'd0;
    bus.EX_NEXT_PC  = 32'd0;
    bus.EX_RD_SEL   = 2'd0;
  endtask

  task automatic ex_garbage();
    bus.EX_VALID    = 1'b1;
    bus.EX_MEM_RD   = 1'($urandom);
    bus.EX_MEM_WR   = 1'($urandom);
    bus.EX_ALU_RES  = $urandom;
    bus.EX_RS2_DATA = $urandom;
    bus.EX_SIZE     = 2'($urandom);
    bus.EX_UNSIGNED = 1'($urandom);
    bus.EX_RF_D_SEL = 2'($urandom);
    bus.EX_NEXT_PC  = $urandom;
    bus.EX_RD_SEL   = 2'($urandom);
  endtask

  // Reference helpers: access width in bytes and derived quantities.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int n);
    logic [63:0] mask, lo, acc;
    mask = (64'd1 << (8 * n)) - 64'd1;
    lo   = {32'd0, d} & mask;
    acc  = 64'd0;
    for (int k = 0; k < 4 / n; k++) acc = acc + (lo << (8 * n * k));
    return acc[31:0];
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input int off, input int n,
                                           input bit uns);
    logic [63:0] mask, lane;
    mask = (64'd1 << (8 * n)) - 64'd1;
    lane = ({32'd0, rd} >> (8 * off)) & mask;
    if (!uns && n < 4 && lane >= (64'd1 << (8 * n - 1))) lane = lane - (64'd1 << (8 * n));
    return lane[31:0];
  endfunction

  // Runs one instruction starting just after a rising edge and leaves the
  // bench just after a rising edge with the EX side idle.
  task automatic run_op(input string nm, input bit v, input bit rd, input bit wr,
                        input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int waits,
                        input logic [1:0] rfs, input logic [1:0] rds, input logic [31:0] npc);
    bit          memop, mis, store;
    int          n, off, stall_cnt;
    logic [31:0] exp_q;
    n     = nbytes(sz);
    off   = int'(a % 4);
    memop = v && (rd || wr);
    store = wr;
    mis   = memop && ((off % n) != 0);
    exp_q = store ? 32'd0 : exp_load(rdat, off, n, uns);

    bus.EX_VALID = v;        bus.EX_MEM_RD = rd;       bus.EX_MEM_WR = wr;
    bus.EX_SIZE = sz;        bus.EX_UNSIGNED = uns;    bus.EX_ALU_RES = a;
    bus.EX_RS2_DATA = wd;    bus.EX_RF_D_SEL = rfs;    bus.EX_RD_SEL = rds;
    bus.EX_NEXT_PC = npc;    bus.DM_ACK = 1'b0;

    @(negedge clk);
    chk({nm, ".stall_issue"}, 32'(bus.STALL), 32'(memop && !mis));
    stall_cnt = bus.STALL ? 1 : 0;
    @(posedge clk); #1;

    if (!memop) begin
      chk({nm, ".valid"}, 32'(bus.MEM_VALID), 32'(v));
      chk({nm, ".alu"}, bus.MEM_ALU_RES, a);
      chk({nm, ".dmq"}, bus.MEM_DM_Q, 32'd0);
      chk({nm, ".pass"}, {bus.MEM_NEXT_PC[27:0], bus.MEM_RF_D_SEL, bus.MEM_RD_SEL},
          {npc[27:0], rfs, rds});
      chk({nm, ".req"}, 32'(bus.DM_REQ), 32'd0);
      ex_idle();
    end else if (mis) begin
      chk({nm, ".misalign"}, 32'(bus.MISALIGN), 32'd1);
      chk({nm, ".mis_valid"}, 32'(bus.MEM_VALID), 32'd0);
      chk({nm, ".mis_req"}, 32'(bus.DM_REQ), 32'd0);
      ex_idle();
      @(posedge clk); #1;
      chk({nm, ".misalign_end"}, 32'(bus.MISALIGN), 32'd0);
      chk({nm, ".mis_req2"}, 32'(bus.DM_REQ), 32'd0);
    end else begin
      chk({nm, ".req"}, 32'(bus.DM_REQ), 32'd1);
      chk({nm, ".we"}, 32'(bus.DM_WE), 32'(store));
      chk({nm, ".addr"}, bus.DM_ADDR, a & 32'hFFFF_FFFC);
      chk({nm, ".be"}, 32'(bus.DM_BE), 32'(((1 << n) - 1) << off));
      if (store) chk({nm, ".wdata"}, bus.DM_WDATA, exp_wdata(wd, n));
      chk({nm, ".acc_valid"}, 32'(bus.MEM_VALID), 32'd0);
      ex_garbage();
      for (int i = 0; i < waits; i++) begin
        bus.DM_ACK   = 1'b0;
        bus.DM_RDATA = $urandom;
        @(negedge clk);
        if (bus.STALL) stall_cnt++;
        @(posedge clk); #1;
        chk({nm, ".wait_valid"}, 32'(bus.MEM_VALID), 32'd0);
        chk({nm, ".hold"}, {bus.DM_ADDR[31:2], bus.DM_BE[1:0]},
            {a[31:2], 2'(((1 << n) - 1) << off)});
        chk({nm, ".hold_req"}, 32'(bus.DM_REQ), 32'd1);
        ex_garbage();
      end
      bus.DM_ACK   = 1'b1;
      bus.DM_RDATA = rdat;
      @(negedge clk);
      chk({nm, ".stall_ack"}, 32'(bus.STALL), 32'd0);
      chk({nm, ".stall_cycles"}, 32'(stall_cnt), 32'(1 + waits));
      @(posedge clk); #1;
      bus.DM_ACK = 1'b0;
      ex_idle();
      chk({nm, ".ack_valid"}, 32'(bus.MEM_VALID), 32'd1);
      chk({nm, ".ack_req"}, 32'(bus.DM_REQ), 32'd0);
      chk({nm, ".ack_alu"}, bus.MEM_ALU_RES, a);
      chk({nm, ".ack_dmq"}, bus.MEM_DM_Q, exp_q);
      chk({nm, ".ack_pass"}, {bus.MEM_NEXT_PC[27:0], bus.MEM_RF_D_SEL, bus.MEM_RD_SEL},
          {npc[27:0], rfs, rds});
      bus.DM_ACK = 1'(($urandom));
      @(posedge clk); #1;
      bus.DM_ACK = 1'b0;
      chk({nm, ".pulse_end"}, 32'(bus.MEM_VALID), 32'd0);
      chk({nm, ".idle_req"}, 32'(bus.DM_REQ), 32'd0);
    end
  endtask

  initial begin
    ex_idle();
    bus.DM_ACK   = 1'b0;
    bus.DM_RDATA = 32'd0;

    #12;
    chk("rst.req", 32'(bus.DM_REQ), 32'd0);
    chk("rst.stall", 32'(bus.STALL), 32'd0);
    chk("rst.misalign", 32'(bus.MISALIGN), 32'd0);
    chk("rst.valid", 32'(bus.MEM_VALID), 32'd0);
    chk("rst.addr", bus.DM_ADDR, 32'd0);
    chk("rst.alu", bus.MEM_ALU_RES, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("alu", 1, 0, 0, 2'd2, 0, 32'h0000_1234, 32'd0, 32'd0, 0, 2'd1, 2'd2, 32'h0000_0040);
    run_op("lb_sgn", 1, 1, 0, 2'd0, 0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 2, 2'd2, 2'd1, 32'h44);
    run_op("sh", 1, 0, 1, 2'd1, 0, 32'h0000_0022, 32'h0000_ABCD, 32'd0, 0, 2'd0, 2'd0, 32'h48);
    run_op("lw_mis", 1, 1, 0, 2'd2, 0, 32'h0000_0101, 32'd0, 32'd0, 0, 2'd1, 2'd1, 32'h4C);
    run_op("lhu", 1, 1, 0, 2'd1, 1, 32'h0000_0002, 32'd0, 32'h9876_0000, 1, 2'd3, 2'd3, 32'h50);
    run_op("rdwr", 1, 1, 1, 2'd2, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_2222, 1, 2'd1, 2'd0,
           32'h54);
    run_op("bubble", 0, 1, 0, 2'd2, 0, 32'h0000_0008, 32'd0, 32'd0, 0, 2'd0, 2'd0, 32'h58);

    // Reset during the second ACCESS cycle aborts the access.
    bus.EX_VALID = 1'b1; bus.EX_MEM_RD = 1'b1; bus.EX_SIZE = 2'd2;
    bus.EX_ALU_RES = 32'h0000_0200;
    @(posedge clk); #1;
    chk("abort.req_up", 32'(bus.DM_REQ), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort.req", 32'(bus.DM_REQ), 32'd0);
    chk("abort.stall", 32'(bus.STALL), 32'd0);
    chk("abort.valid", 32'(bus.MEM_VALID), 32'd0);
    @(negedge clk);
    ex_idle();
    rst = 1'b0;
    bus.DM_ACK = 1'b1;
    bus.DM_RDATA = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort.no_pulse", 32'(bus.MEM_VALID), 32'd0);
      chk("abort.no_req", 32'(bus.DM_REQ), 32'd0);
    end
    bus.DM_ACK = 1'b0;
    run_op("post_rst", 1, 0, 0, 2'd0, 0, 32'h0000_0777, 32'd0, 32'd0, 0, 2'd2, 2'd1, 32'h60);

    for (int t = 0; t < 60; t++) begin
      logic [1:0]  kind, sz;
      logic [31:0] a;
      kind = 2'($urandom);
      sz   = 2'($urandom);
      a    = $urandom;
      run_op("rnd", (kind != 2'd3) || ($urandom_range(0, 3) == 0), kind[0], kind[1] & kind[0]
             ? 1'($urandom) : kind[1], sz, 1'($urandom), a, $urandom, $urandom,
             int'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
